fp_subtractor_seq: RTL

Multi-cycle IEEE-754 single-precision subtractor computing resultSub = A − B under four rounding modes. It sits in the FPU beside the combinational adder and provides the subtract direction. Unlike the adder, it performs full left-normalization after cancellation and proper guard/round/sticky rounding. Operation uses a start/done handshake with a state machine that normalizes one bit per cycle.

---
 rtl/fp_subtractor_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle IEEE-754 single-precision A - B with full
// left normalization (one bit per cycle) and guard/round/sticky rounding.
module fp_subtractor_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultSub,
  output logic        errorSub,
  output logic        overflowSub,
  output logic        underflowSub
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;

  state_t      state;

  logic [31:0] a_q, b_q;
  logic [1:0]  mode_q;
  logic [26:0] sig_a, sig_b;
  logic        sign_a, sign_b, sign_r;
  logic [27:0] sum;
  logic [9:0]  exp_r;

  function automatic logic [26:0] shift_sticky(input logic [26:0] sig, input logic [7:0] amt);
    logic [26:0] mask;
    if (amt >= 8'd26) return {26'd0, |sig};
    mask = (27'd1 << amt) - 27'd1;
    return (sig >> amt) | {26'd0, |(sig & mask)};
  endfunction

  function automatic logic round_inc(input logic [1:0] mode, input logic sign, input logic lsb,
                                     input logic g, input logic r, input logic s);
    case (mode)
      2'b01:   return g & (r | s | lsb);
      2'b10:   return ~sign & (g | r | s);
      2'b11:   return sign & (g | r | s);
      default: return 1'b0;
    endcase
  endfunction

  // Alignment inputs: exponent-0 operands are flushed to a zero significand
  logic [7:0]  exp_a, exp_b;
  logic [26:0] raw_a, raw_b;
  logic        special, a_big, a_ge;

  assign exp_a   = a_q[30:23];
  assign exp_b   = b_q[30:23];
  assign raw_a   = (exp_a == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
  assign raw_b   = (exp_b == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
  assign special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
  assign a_big   = exp_a >= exp_b;
  assign a_ge    = sig_a >= sig_b;

  logic norm_zero, norm_carry, norm_hid, norm_flush;

  assign norm_zero  = (sum == 28'd0);
  assign norm_carry = sum[27];
  assign norm_hid   = sum[26];
  assign norm_flush = (exp_r == 10'd1);

  logic        inc;
  logic [24:0] mant_rnd;
  logic [9:0]  exp_rnd;
  logic [22:0] frac_rnd;
  logic        ovf;
  logic [31:0] rnd_result;

  assign inc        = round_inc(mode_q, sign_r, sum[3], sum[2], sum[1], sum[0]);
  assign mant_rnd   = {1'b0, sum[26:3]} + {24'd0, inc};
  assign exp_rnd    = mant_rnd[24] ? exp_r + 10'd1 : exp_r;
  assign frac_rnd   = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
  assign ovf        = exp_rnd >= 10'd255;
  assign rnd_result = ovf ? {sign_r, 8'hFF, 23'd0} : {sign_r, exp_rnd[7:0], frac_rnd};

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_q    <= A;
        b_q    <= B;
        mode_q <= round_mode;
      end
      ALIGN: begin
        sign_a <= a_q[31];
        sign_b <= ~b_q[31];
        if (a_big) begin
          exp_r <= {2'b00, exp_a};
          sig_a <= raw_a;
          sig_b <= shift_sticky(raw_b, exp_a - exp_b);
        end else begin
          exp_r <= {2'b00, exp_b};
          sig_a <= shift_sticky(raw_a, exp_b - exp_a);
          sig_b <= raw_b;
        end
      end
      ADDSUB: begin
        if (sign_a == sign_b) begin
          sum    <= {1'b0, sig_a} + {1'b0, sig_b};
          sign_r <= sign_a;
        end else if (a_ge) begin
          sum    <= {1'b0, sig_a} - {1'b0, sig_b};
          sign_r <= sign_a;
        end else begin
          sum    <= {1'b0, sig_b} - {1'b0, sig_a};
          sign_r <= sign_b;
        end
      end
      NORM: begin
        if (norm_zero) begin
          sign_r <= (mode_q == 2'b11);
          exp_r  <= 10'd0;
        end else if (norm_carry) begin
          sum   <= {1'b0, sum[27:2], sum[1] | sum[0]};
          exp_r <= exp_r + 10'd1;
        end else if (norm_hid) begin
          sum <= sum;
        end else if (norm_flush) begin
          sum   <= 28'd0;
          exp_r <= 10'd0;
        end else begin
          sum   <= {sum[26:0], 1'b0};
          exp_r <= exp_r - 10'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      resultSub    <= 32'd0;
      errorSub     <= 1'b0;
      overflowSub  <= 1'b0;
      underflowSub <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= ALIGN;
          busy         <= 1'b1;
          errorSub     <= 1'b0;
          overflowSub  <= 1'b0;
          underflowSub <= 1'b0;
        end
        ALIGN: begin
          if (special) begin
            resultSub <= 32'h7FC00000;
            errorSub  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= ADDSUB;
          end
        end
        ADDSUB: state <= NORM;
        NORM: begin
          if (norm_zero || norm_carry || norm_hid) begin
            state <= ROUND;
          end else if (norm_flush) begin
            underflowSub <= 1'b1;
            state        <= ROUND;
          end
        end
        ROUND: begin
          resultSub   <= rnd_result;
          overflowSub <= ovf;
          errorSub    <= ovf;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
